// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter owner and instruction presenter
// for a synchronous-read program memory with one cycle of latency.
module fetch_sequencer #(
  parameter int         AB      = 11,
  parameter int         DB      = 16,
  parameter logic [4:0] HALT_OP = 5'b00000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AB-1:0] start_addr,
  output logic [AB-1:0] mem_addr,
  input  logic [DB-1:0] mem_data,
  output logic [DB-1:0] instr,
  output logic [AB-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jump_en,
  input  logic [AB-1:0] jump_addr,
  output logic          halted,
  output logic [15:0]   retired_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]    state_q, state_d;
  logic [AB-1:0] pc_q, pc_d;
  logic [15:0]   cnt_q, cnt_d;

  logic is_halt;
  logic cnt_inc;
  logic cnt_clr;

  assign is_halt = (mem_data[DB-1 -: 5] == HALT_OP);

  // Outputs are a pure function of state and pc; instr follows mem_data.
  assign mem_addr      = pc_q;
  assign instr_pc      = pc_q;
  assign instr_valid   = (state_q == S_VALID);
  assign instr         = instr_valid ? mem_data : '0;
  assign halted        = (state_q == S_HALTED);
  assign retired_count = cnt_q;

  // Next state and pc; jump beats handshake, start only when stopped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = start_addr;
          cnt_clr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (jump_en) begin
          pc_d = jump_addr;
        end else begin
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (jump_en) begin
          pc_d    = jump_addr;
          state_d = S_FETCH;
        end else if (instr_ready && is_halt) begin
          cnt_inc = 1'b1;
          state_d = S_HALTED;
        end else if (instr_ready) begin
          cnt_inc = 1'b1;
          pc_d    = pc_q + AB'(1);
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired counter: cleared on start, saturating on handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
